branch_resolve_queue: RTL and testbench

Tracks in-flight conditional branches between fetch, where the global-history predictor makes its guess, and execute, where the branch resolves. Fetch pushes each predicted branch's low address and predicted direction into an in-order queue. When execute resolves the oldest branch, the block:
- emits the renew_valid/renew_addr/renew_result training update for the predictor;
- flags a mispredict when the prediction was wrong, and flushes all younger entries.

---
 rtl/branch_resolve_queue_pkg.sv | 14 +
 rtl/branch_queue_fifo.sv | 56 +++++
 rtl/branch_resolve_queue.sv | 89 ++++++++
 tb/tb_branch_resolve_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch predictor and its resolve queue.
// Keeps the address index width and counter encoding in one place.
package branch_resolve_queue_pkg;

   localparam int BRQ_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      STRONG_NO_JUMP = 2'b00,
      WEAK_NO_JUMP   = 2'b01,
      WEAK_JUMP      = 2'b10,
      STRONG_JUMP    = 2'b11
   } ctr_state_t;

endpackage

// File: rtl/branch_queue_fifo.sv
// Circular buffer of in-flight branches with clear and truncate.
// Pointers carry one extra bit so full and empty are distinguishable.
module branch_queue_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter int WIDTH     = BRQ_ADDR_WIDTH + 1,
   parameter int DEPTH_LOG = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 trunc,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     push_data,
   output logic [WIDTH-1:0]     head,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [DEPTH_LOG:0] wptr;
   logic [DEPTH_LOG:0] rptr;

   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = count[DEPTH_LOG];
   assign head  = mem[rptr[DEPTH_LOG-1:0]];

   // Pointer update: clear empties, trunc pops head and drops the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else if (trunc) begin
         rptr <= rptr + PTR_ONE;
         wptr <= rptr + PTR_ONE;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Entry storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[DEPTH_LOG-1:0]] <= push_data;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution.
// Produces predictor training updates and mispredict flushes.
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int LOW_ADDR_WIDTH = BRQ_ADDR_WIDTH,
   parameter int DEPTH_LOG      = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_valid,
   input  logic [LOW_ADDR_WIDTH-1:0] push_addr,
   input  logic                      push_pred,
   output logic                      push_ready,
   input  logic                      resolve_valid,
   input  logic                      resolve_taken,
   input  logic                      flush_in,
   output logic                      renew_valid,
   output logic [LOW_ADDR_WIDTH-1:0] renew_addr,
   output logic                      renew_result,
   output logic                      mispredict,
   output logic                      resolve_err,
   output logic [DEPTH_LOG:0]        occupancy,
   output logic [CNT_WIDTH-1:0]      mispredict_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [LOW_ADDR_WIDTH:0] head;
   logic                    full;
   logic                    empty;
   logic                    resolve_fire;
   logic                    miss;
   logic                    push_fire;
   logic                    err;

   assign push_ready   = ~full;
   assign resolve_fire = resolve_valid & ~empty & ~flush_in;
   assign miss         = resolve_fire & (head[0] != resolve_taken);
   assign push_fire    = push_valid & ~full & ~flush_in & ~miss;
   assign err          = resolve_valid & empty & ~flush_in;

   branch_queue_fifo #(
      .WIDTH     (LOW_ADDR_WIDTH + 1),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush_in),
      .trunc     (miss),
      .push      (push_fire),
      .pop       (resolve_fire),
      .push_data ({push_addr, push_pred}),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (occupancy)
   );

   // Registered resolve outputs; addr/result hold between renews.
   always_ff @(posedge clk) begin
      if (rst) begin
         renew_valid  <= 1'b0;
         renew_addr   <= '0;
         renew_result <= 1'b0;
         mispredict   <= 1'b0;
         resolve_err  <= 1'b0;
      end else begin
         renew_valid <= resolve_fire;
         mispredict  <= miss;
         resolve_err <= err;
         if (resolve_fire) begin
            renew_addr   <= head[LOW_ADDR_WIDTH:1];
            renew_result <= resolve_taken;
         end
      end
   end

   // Saturating mispredict counter, survives pipeline flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_cnt <= '0;
      end else if (miss && (mispredict_cnt != '1)) begin
         mispredict_cnt <= mispredict_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed check of branch_resolve_queue against a queue model.
// A second instance with a 2-bit counter covers saturation.
module tb_branch_resolve_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       push_valid;
   logic [7:0] push_addr;
   logic       push_pred;
   logic       push_ready;
   logic       resolve_valid;
   logic       resolve_taken;
   logic       flush_in;
   logic       renew_valid;
   logic [7:0] renew_addr;
   logic       renew_result;
   logic       mispredict;
   logic       resolve_err;
   logic [2:0] occupancy;
   logic [15:0] mispredict_cnt;

   logic       s_push_ready;
   logic       s_renew_valid;
   logic [7:0] s_renew_addr;
   logic       s_renew_result;
   logic       s_mispredict;
   logic       s_resolve_err;
   logic [2:0] s_occupancy;
   logic [1:0] s_cnt;

   typedef struct {
      logic [7:0] addr;
      logic       pred;
   } ent_t;

   ent_t        q[$];
   logic [7:0]  m_addr;
   logic        m_result;
   int unsigned m_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_queue dut (
      .clk            (clk),
      .rst            (rst),
      .push_valid     (push_valid),
      .push_addr      (push_addr),
      .push_pred      (push_pred),
      .push_ready     (push_ready),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .flush_in       (flush_in),
      .renew_valid    (renew_valid),
      .renew_addr     (renew_addr),
      .renew_result   (renew_result),
      .mispredict     (mispredict),
      .resolve_err    (resolve_err),
      .occupancy      (occupancy),
      .mispredict_cnt (mispredict_cnt)
   );

   branch_resolve_queue #(.CNT_WIDTH(2)) dut_sat (
      .clk            (clk),
      .rst            (rst),
      .push_valid     (push_valid),
      .push_addr      (push_addr),
      .push_pred      (push_pred),
      .push_ready     (s_push_ready),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .flush_in       (flush_in),
      .renew_valid    (s_renew_valid),
      .renew_addr     (s_renew_addr),
      .renew_result   (s_renew_result),
      .mispredict     (s_mispredict),
      .resolve_err    (s_resolve_err),
      .occupancy      (s_occupancy),
      .mispredict_cnt (s_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic step(input bit r, input bit f, input bit pv,
                       input logic [7:0] pa, input bit pp,
                       input bit rv, input bit rt);
      bit   e_rv, e_mis, e_err, was_full;
      ent_t h;
      int   sat;
      rst = r; flush_in = f; push_valid = pv; push_addr = pa;
      push_pred = pp; resolve_valid = rv; resolve_taken = rt;
      e_rv = 0; e_mis = 0; e_err = 0;
      was_full = (q.size() == 4);
      if (r) begin
         q.delete(); m_cnt = 0; m_addr = 0; m_result = 0;
      end else if (f) begin
         q.delete();
      end else begin
         if (rv && q.size() == 0) begin
            e_err = 1;
         end else if (rv) begin
            h = q.pop_front();
            e_rv = 1; m_addr = h.addr; m_result = rt;
            if (h.pred != rt) begin
               e_mis = 1;
               q.delete();
               if (m_cnt < 65535) m_cnt++;
            end
         end
         if (pv && !was_full && !e_mis) q.push_back('{pa, pp});
      end
      @(posedge clk);
      #1;
      sat = (m_cnt > 3) ? 3 : m_cnt;
      check("renew_valid", renew_valid, e_rv);
      check("renew_addr", renew_addr, m_addr);
      check("renew_result", renew_result, m_result);
      check("mispredict", mispredict, e_mis);
      check("resolve_err", resolve_err, e_err);
      check("occupancy", occupancy, q.size());
      check("push_ready", push_ready, q.size() != 4);
      check("mispredict_cnt", mispredict_cnt, m_cnt);
      check("sat_cnt", s_cnt, sat);
   endtask

   function automatic bit head_pred();
      return (q.size() != 0) ? q[0].pred : 1'b0;
   endfunction

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 8'h12, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      for (int i = 1; i <= 5; i++) step(0, 0, 1, 8'(i), 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 1, 8'h10, 1, 0, 0);
      step(0, 0, 1, 8'h20, 0, 0, 0);
      step(0, 0, 1, 8'h30, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 1, 8'h41, 1, 0, 0);
      step(0, 0, 1, 8'h42, 0, 0, 0);
      step(0, 0, 1, 8'h43, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h50 + 8'(i), 1, 0, 0);
      step(0, 0, 1, 8'h5f, 0, 1, 1);
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, 8'h60 + 8'(i), i[0], 1, head_pred());
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, head_pred());
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 8'h70 + 8'(i), 1, 0, 0);
         step(0, 0, 0, 0, 0, 1, 0);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h80 + 8'(i), 1, 0, 0);
      step(1, 0, 1, 8'h90, 1, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         bit rt;
         rt = ($urandom_range(0, 3) == 0) ? ~head_pred() : head_pred();
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 60,
              8'($urandom),
              1'($urandom),
              $urandom_range(0, 99) < 45,
              rt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
